nand_serial_arbiter: RTL and testbench

- Shares one external 2-input NAND gate between NREQ requesters; each requester needs a WIDTH-bit bitwise NAND.
- Round-robin arbitration picks one requester, captures its operands, streams them LSB-first through the shared gate one bit per cycle, then returns the assembled result with a one-cycle done pulse.
- Sits between requester logic and a single NAND cell instance; the gate's inputs and output are block ports.

---
 rtl/nand_serial_arbiter.sv | 166 ++++++++++++++++
 tb/tb_nand_serial_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_serial_arbiter.sv
// Round-robin arbiter that time-shares one external 2-input NAND gate between
// NREQ requesters, streaming each WIDTH-bit operand pair LSB-first through it.
module nand_serial_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      res,
    output logic [NREQ-1:0]       done,
    output logic                  nand_a,
    output logic                  nand_b,
    input  logic                  nand_y
);

    localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CW = $clog2(WIDTH);
    localparam int unsigned NR = NREQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_win;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_pick;
    int unsigned       w_sum;
    logic              w_found;

    logic [CW-1:0]     r_cnt;
    logic              w_last;

    logic [WIDTH-1:0]  r_sa;
    logic [WIDTH-1:0]  r_sb;
    logic [WIDTH-1:0]  r_rs;
    logic [WIDTH-1:0]  w_rs_nxt;
    logic [WIDTH-1:0]  w_a_win;
    logic [WIDTH-1:0]  w_b_win;
    logic [WIDTH-1:0]  r_res;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic              r_nand_a;
    logic              r_nand_b;

    // Wrapped upward search starting at the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = 0;
        w_pick  = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            w_sum = 32'(r_ptr) + k;
            if (w_sum >= NR) begin
                w_sum = w_sum - NR;
            end
            w_pick = PW'(w_sum);
            if (!w_found && req[w_pick]) begin
                w_found = 1'b1;
                w_win   = w_pick;
            end
        end
    end

    assign w_a_win  = op_a[w_win*WIDTH +: WIDTH];
    assign w_b_win  = op_b[w_win*WIDTH +: WIDTH];
    assign w_rs_nxt = {nand_y, r_rs[WIDTH-1:1]};
    assign w_last   = (r_cnt == CW'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Gate inputs are flops preloaded one edge ahead so they are glitch-free for
    // each whole SHIFT cycle; res/done load on the last shift edge so both are
    // visible during the DONE cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_win    <= '0;
            r_cnt    <= '0;
            r_sa     <= '0;
            r_sb     <= '0;
            r_rs     <= '0;
            r_res    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_nand_a <= 1'b0;
            r_nand_b <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= '0;
                    if (w_found) begin
                        r_sa     <= w_a_win;
                        r_sb     <= w_b_win;
                        r_nand_a <= w_a_win[0];
                        r_nand_b <= w_b_win[0];
                        r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_win    <= w_win;
                        r_cnt    <= '0;
                        r_rs     <= '0;
                    end
                end
                S_SHIFT: begin
                    r_rs  <= w_rs_nxt;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_res    <= w_rs_nxt;
                        r_done   <= r_gnt;
                        r_nand_a <= 1'b0;
                        r_nand_b <= 1'b0;
                    end else begin
                        r_nand_a <= r_sa[1];
                        r_nand_b <= r_sb[1];
                    end
                end
                S_DONE: begin
                    r_done <= '0;
                    r_gnt  <= '0;
                    r_ptr  <= (r_win == PW'(NREQ-1)) ? '0 : r_win + 1'b1;
                end
                default: begin
                    r_done   <= '0;
                    r_gnt    <= '0;
                    r_nand_a <= 1'b0;
                    r_nand_b <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign busy   = (r_state != S_IDLE);
    assign res    = r_res;
    assign done   = r_done;
    assign nand_a = r_nand_a;
    assign nand_b = r_nand_b;

endmodule

// File: tb/tb_nand_serial_arbiter.sv
// Directed and randomized bench for nand_serial_arbiter, with an external NAND
// gate model and a round-robin reference model held in plain variables.
module tb_nand_serial_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      res;
    logic [NREQ-1:0]       done;
    logic                  nand_a;
    logic                  nand_b;
    logic                  nand_y;

    int               checks;
    int               failures;
    int               ptr;
    logic [WIDTH-1:0] exp_res;

    nand_serial_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op_a   (op_a),
        .op_b   (op_b),
        .gnt    (gnt),
        .busy   (busy),
        .res    (res),
        .done   (done),
        .nand_a (nand_a),
        .nand_b (nand_b),
        .nand_y (nand_y)
    );

    assign nand_y = ~(nand_a & nand_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ops();
        for (int r = 0; r < NREQ; r++) begin
            op_a[r*WIDTH +: WIDTH] = WIDTH'($urandom);
            op_b[r*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // One full operation starting from IDLE; leaves the bench in the IDLE cycle.
    task automatic run_op(input logic [NREQ-1:0] mask, input bit drop, input bit hold);
        int               w;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [31:0]      onehot;
        w      = pick(mask, ptr);
        a      = op_a[w*WIDTH +: WIDTH];
        b      = op_b[w*WIDTH +: WIDTH];
        onehot = 32'(1) << w;
        req    = mask;
        step();
        if (drop) req = '0;
        scramble_ops();
        for (int i = 0; i < WIDTH; i++) begin
            check("shift_gnt", 32'(gnt), onehot);
            check("shift_busy", 32'(busy), 1);
            check("shift_done", 32'(done), 0);
            check("shift_nand_a", 32'(nand_a), 32'(a[i]));
            check("shift_nand_b", 32'(nand_b), 32'(b[i]));
            step();
        end
        exp_res = ~(a & b);
        ptr     = (w + 1) % NREQ;
        check("done_pulse", 32'(done), onehot);
        check("done_res", 32'(res), 32'(exp_res));
        check("done_gnt", 32'(gnt), onehot);
        check("done_busy", 32'(busy), 1);
        check("done_nand", 32'({nand_a, nand_b}), 0);
        if (!hold) req = '0;
        step();
        check("idle_gnt", 32'(gnt), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("idle_res_hold", 32'(res), 32'(exp_res));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ptr      = 0;
        exp_res  = '0;
        rst      = 1'b1;
        req      = '0;
        op_a     = '0;
        op_b     = '0;
        step();
        step();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_res", 32'(res), 0);
        check("rst_done", 32'(done), 0);
        check("rst_nand", 32'({nand_a, nand_b}), 0);
        rst = 1'b0;
        step();
        check("idle_no_req_gnt", 32'(gnt), 0);

        // Single op on requester 0
        scramble_ops();
        op_a[7:0] = 8'hF0;
        op_b[7:0] = 8'hCC;
        run_op(4'b0001, 1'b0, 1'b0);
        check("single_res_literal", 32'(res), 32'h3F);

        // Corner operands
        op_a[15:8] = 8'hFF; op_b[15:8] = 8'hFF;
        run_op(4'b0010, 1'b0, 1'b0);
        check("corner_ff_ff", 32'(res), 32'h00);
        op_a[23:16] = 8'h00; op_b[23:16] = 8'h5A;
        run_op(4'b0100, 1'b0, 1'b0);
        check("corner_00_5a", 32'(res), 32'hFF);
        op_a[31:24] = 8'hAA; op_b[31:24] = 8'h55;
        run_op(4'b1000, 1'b0, 1'b0);
        check("corner_aa_55", 32'(res), 32'hFF);

        // Round robin with all requests held: order 0,1,2,3,0
        for (int n = 0; n < 5; n++) begin
            check("rr_order", 32'(pick(4'b1111, ptr)), 32'(n % NREQ));
            run_op(4'b1111, 1'b0, (n != 4));
        end

        // Request pulse dropped right after the grant
        run_op(4'b0010, 1'b1, 1'b0);

        // Pointer skip: after serving 2, requester 3 wins over 1
        run_op(4'b0100, 1'b0, 1'b0);
        check("skip_ptr", 32'(ptr), 3);
        run_op(4'b1010, 1'b0, 1'b0);
        run_op(4'b1010, 1'b0, 1'b0);

        // Reset during the 4th SHIFT cycle
        req = 4'b0001;
        step();
        req = '0;
        step();
        step();
        step();
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        check("midrst_gnt", 32'(gnt), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_res", 32'(res), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_nand", 32'({nand_a, nand_b}), 0);
        rst     = 1'b0;
        ptr     = 0;
        exp_res = '0;
        step();
        check("post_rst_done", 32'(done), 0);
        run_op(4'b0101, 1'b0, 1'b0);
        run_op(4'b0100, 1'b0, 1'b0);

        // Randomized operations
        for (int n = 0; n < 16; n++) begin
            scramble_ops();
            run_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), bit'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                step();
                check("rand_idle_gnt", 32'(gnt), 0);
                check("rand_idle_res", 32'(res), 32'(exp_res));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
